// File: rtl/cla_multiword_sched_if.sv
// Request/result bus for cla_multiword_sched.
//   master: requesters + consumer (drive req_valid, operands, out_ready)
//   slave : the sequencer (drives req_ready, out_valid, out_id, Sum, C_out[, ovf])
// Optional macro CLA_SCHED_OVF_EN adds the signed-overflow flag ovf.
interface cla_multiword_sched_if #(
    parameter int unsigned NCHUNK = 4
);
    localparam int unsigned W = 5 * NCHUNK;

    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] A0;
    logic [W-1:0] B0;
    logic         C_in0;
    logic [W-1:0] A1;
    logic [W-1:0] B1;
    logic         C_in1;
    logic         out_valid;
    logic         out_ready;
    logic         out_id;
    logic [W-1:0] Sum;
    logic         C_out;
`ifdef CLA_SCHED_OVF_EN
    logic         ovf;
`endif

    modport master (
        output req_valid, A0, B0, C_in0, A1, B1, C_in1, out_ready,
        input  req_ready, out_valid, out_id, Sum, C_out
`ifdef CLA_SCHED_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  req_valid, A0, B0, C_in0, A1, B1, C_in1, out_ready,
        output req_ready, out_valid, out_id, Sum, C_out
`ifdef CLA_SCHED_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/cla_5bit.sv
// 5-bit carry-lookahead adder, purely combinational.
//   A, B  : operands      C_in : carry in
//   Sum   : A+B+C_in mod 32   C_out : carry out of bit 4
module cla_5bit (
    input  logic [4:0] A,
    input  logic [4:0] B,
    input  logic       C_in,
    output logic [4:0] Sum,
    output logic       C_out
);
    logic [4:0] g;
    logic [4:0] p;
    logic [5:0] c;

    // Generate/propagate terms and flattened lookahead carries.
    always_comb begin
        g    = A & B;
        p    = A ^ B;
        c[0] = C_in;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        c[5] = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2])
             | (p[4] & p[3] & p[2] & g[1])
             | (p[4] & p[3] & p[2] & p[1] & g[0])
             | (p[4] & p[3] & p[2] & p[1] & p[0] & c[0]);
        Sum   = p ^ c[4:0];
        C_out = c[5];
    end
endmodule

// File: rtl/cla_multiword_sched.sv
// Two-requester round-robin sequencer that adds 5*NCHUNK-bit operands through
// one cla_5bit, one chunk per cycle LSB first, carry held in a register.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of cla_multiword_sched_if (requests in, result out)
// Optional macro CLA_SCHED_OVF_EN adds the registered signed-overflow flag ovf.
module cla_multiword_sched #(
    parameter int unsigned NCHUNK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    cla_multiword_sched_if.slave  bus
);
    localparam int unsigned W  = 5 * NCHUNK;
    localparam int unsigned KW = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          last_grant_q;
    logic          id_q;
    logic [KW-1:0] k_q;
    logic          carry_q;
    logic [W-1:0]  a_q, b_q, sum_q;
    logic          c_out_q;
    logic          out_valid_q;
`ifdef CLA_SCHED_OVF_EN
    logic          ovf_q;
`endif

    logic          grant_c;
    logic          accept_c;
    logic          last_chunk_c;
    logic [4:0]    chunk_a_c, chunk_b_c, chunk_sum_c;
    logic          chunk_cout_c;

    // Round-robin pick: a lone requester wins, contention goes to the other one.
    always_comb begin
        grant_c = 1'b0;
        if (bus.req_valid[0] && bus.req_valid[1]) begin
            grant_c = ~last_grant_q;
        end else if (bus.req_valid[1]) begin
            grant_c = 1'b1;
        end
    end

    assign accept_c     = (state_q == S_IDLE) && (|bus.req_valid) && !rst;
    assign bus.req_ready = accept_c ? (grant_c ? 2'b10 : 2'b01) : 2'b00;
    assign last_chunk_c = (k_q == KW'(NCHUNK - 1));

    // Current chunk slice of the captured operands.
    assign chunk_a_c = a_q[5*k_q +: 5];
    assign chunk_b_c = b_q[5*k_q +: 5];

    cla_5bit u_cla (
        .A     (chunk_a_c),
        .B     (chunk_b_c),
        .C_in  (carry_q),
        .Sum   (chunk_sum_c),
        .C_out (chunk_cout_c)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept_c)          state_d = S_RUN;
            S_RUN:   if (last_chunk_c)      state_d = S_DONE;
            S_DONE:  if (bus.out_ready)     state_d = S_IDLE;
            default:                        state_d = S_IDLE;
        endcase
    end

    // State, job capture and per-chunk datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            k_q          <= '0;
            carry_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            c_out_q      <= 1'b0;
            out_valid_q  <= 1'b0;
`ifdef CLA_SCHED_OVF_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        a_q          <= grant_c ? bus.A1 : bus.A0;
                        b_q          <= grant_c ? bus.B1 : bus.B0;
                        carry_q      <= grant_c ? bus.C_in1 : bus.C_in0;
                        id_q         <= grant_c;
                        last_grant_q <= grant_c;
                        k_q          <= '0;
                    end
                end
                S_RUN: begin
                    sum_q[5*k_q +: 5] <= chunk_sum_c;
                    carry_q           <= chunk_cout_c;
                    if (last_chunk_c) begin
                        c_out_q <= chunk_cout_c;
                        k_q     <= '0;
`ifdef CLA_SCHED_OVF_EN
                        // Same-sign operands whose result sign differs.
                        ovf_q   <= (a_q[W-1] == b_q[W-1]) && (chunk_sum_c[4] != a_q[W-1]);
`endif
                    end else begin
                        k_q <= KW'(k_q + 1'b1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_id    = id_q;
    assign bus.Sum       = sum_q;
    assign bus.C_out     = c_out_q;
`ifdef CLA_SCHED_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_cla_multiword_sched.sv
// Directed self-checking bench for cla_multiword_sched (NCHUNK = 4, W = 20).
module tb_cla_multiword_sched;
    localparam int unsigned NCHUNK = 4;
    localparam int unsigned W      = 5 * NCHUNK;

    logic clk;
    logic rst;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    int   both_hi  = 0;

    cla_multiword_sched_if #(.NCHUNK(NCHUNK)) bus ();

    cla_multiword_sched #(.NCHUNK(NCHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.req_ready === 2'b11) both_hi++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic drive_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin);
        if (id == 0) begin
            bus.A0 = a; bus.B0 = b; bus.C_in0 = cin;
        end else begin
            bus.A1 = a; bus.B1 = b; bus.C_in1 = cin;
        end
        bus.req_valid[id] = 1'b1;
    endtask

    // Issue one request, check grant, latency and result; optionally drain it.
    task automatic run_job(input string tag, input int id, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic cin,
                           input logic [W-1:0] es, input logic ec, input logic eovf,
                           input bit drain);
        int n;
        @(negedge clk);
        drive_req(id, a, b, cin);
        #1;
        chk({tag, "_ready"}, 32'(bus.req_ready), (id == 0) ? 32'd1 : 32'd2);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[id] = 1'b0;
        n = 1;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(NCHUNK + 1));
        chk({tag, "_sum"},  32'(bus.Sum),    32'(es));
        chk({tag, "_cout"}, 32'(bus.C_out),  32'(ec));
        chk({tag, "_id"},   32'(bus.out_id), 32'(id));
`ifdef CLA_SCHED_OVF_EN
        chk({tag, "_ovf"},  32'(bus.ovf),    32'(eovf));
`else
        if (eovf) begin end
`endif
        if (drain) begin
            bus.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.out_ready = 1'b0;
            chk({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
        end
    endtask

    initial begin
        int n;
        int bad;
        rst = 1'b1;
        bus.req_valid = 2'b11;
        bus.out_ready = 1'b0;
        bus.A0 = '0; bus.B0 = '0; bus.C_in0 = 1'b0;
        bus.A1 = '0; bus.B1 = '0; bus.C_in1 = 1'b0;

        // Reset state, with both requests valid to show ready is gated.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready",  32'(bus.req_ready), 32'd0);
        chk("rst_valid",  32'(bus.out_valid), 32'd0);
        chk("rst_sum",    32'(bus.Sum),       32'd0);
        chk("rst_cout",   32'(bus.C_out),     32'd0);
        chk("rst_id",     32'(bus.out_id),    32'd0);
        bus.req_valid = 2'b00;
        rst = 1'b0;

        // Carry ripple across every chunk.
        run_job("ripple", 0, 20'h00001, 20'hFFFFF, 1'b0, 20'h00000, 1'b1, 1'b0, 1'b1);
        // Chunk boundary crossing.
        run_job("boundary", 1, 20'h0001F, 20'h00001, 1'b0, 20'h00020, 1'b0, 1'b0, 1'b1);
        // Carry-in propagates to the MSB, signed overflow.
        run_job("cin_ovf", 0, 20'h7FFFF, 20'h00000, 1'b1, 20'h80000, 1'b0, 1'b1, 1'b1);

        // Backpressure: result held for 10 cycles while req0 waits.
        run_job("bp", 1, 20'h12345, 20'h0ABCD, 1'b1, 20'h1CF13, 1'b0, 1'b0, 1'b0);
        bus.A0 = 20'h00005; bus.B0 = 20'h00005; bus.C_in0 = 1'b0;
        bus.req_valid[0] = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid !== 1'b1 || bus.Sum !== 20'h1CF13 || bus.C_out !== 1'b0 ||
                bus.out_id !== 1'b1 || bus.req_ready !== 2'b00) bad++;
        end
        chk("bp_hold", 32'(bad), 32'd0);
        bus.req_valid[0] = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_handshake", 32'(bus.out_valid), 32'd0);

        // Reset at k = 2 discards the job.
        @(negedge clk);
        drive_req(0, 20'h12345, 20'h11111, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_sum",  32'(bus.Sum),    32'd0);
        chk("mid_rst_cout", 32'(bus.C_out),  32'd0);
        chk("mid_rst_id",   32'(bus.out_id), 32'd0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("mid_rst_no_valid", 32'(bad), 32'd0);
        run_job("post_rst_req1", 1, 20'h00010, 20'h00020, 1'b1, 20'h00031, 1'b0, 1'b0, 1'b1);

        // Contention from reset: grants alternate starting with req0.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        both_hi = 0;
        bus.out_ready = 1'b1;
        drive_req(0, 20'h00003, 20'h00004, 1'b0);
        drive_req(1, 20'hFFFFF, 20'h00002, 1'b0);
        for (int j = 0; j < 4; j++) begin
            #1;
            n = 0;
            while (bus.req_ready === 2'b00 && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk($sformatf("cont%0d_grant", j), 32'(bus.req_ready), (j % 2 == 0) ? 32'd1 : 32'd2);
            @(posedge clk);
            n = 0;
            while (bus.out_valid !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("cont%0d_id", j), 32'(bus.out_id), 32'(j % 2));
            chk($sformatf("cont%0d_sum", j), 32'(bus.Sum),
                (j % 2 == 0) ? 32'h00007 : 32'h00001);
            chk($sformatf("cont%0d_cout", j), 32'(bus.C_out), (j % 2 == 0) ? 32'd0 : 32'd1);
        end
        bus.req_valid = 2'b00;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("ready_onehot", 32'(both_hi), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/cla_multiword_sched.md
# cla_multiword_sched

Sequencer and two-port arbiter for the 5-bit carry-lookahead adder. It serialises a wide add of 5·NCHUNK bits through one internal `cla_5bit` instance, one 5-bit chunk per cycle, LSB first, with the chunk carry held in a register. Two requesters share the adder under round-robin arbitration, and results return on a valid/ready output port.

## Interface
- `NCHUNK`, default 4: number of 5-bit chunks; operand width W = 5·NCHUNK (20 by default); legal range 1–8.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid[1:0]`  in  2  per-requester request valid.
- `req_ready[1:0]`  out  2  per-requester accept; at most one bit high.
- `A0`, `B0`  in  W each  requester 0 operands.
- `C_in0`  in  1  requester 0 carry-in.
- `A1`, `B1`  in  W each  requester 1 operands.
- `C_in1`  in  1  requester 1 carry-in.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accept.
- `out_id`  out  1  requester index owning the result.
- `Sum`  out  W  result, mod 2^W.
- `C_out`  out  1  carry out of bit W-1.
- `ovf`  out  1  signed overflow; present only with `CLA_SCHED_OVF_EN`.

## Operation
- FSM states:
  - IDLE: no job held.
  - RUN: a job is iterating through chunks.
  - DONE: a result is held for the consumer.
- IDLE:
  - `req_ready[g]` = 1 combinationally for the granted requester g, only if `req_valid[g]` = 1.
  - Grant rule:
    - Only one requester valid: that requester is granted.
    - Both valid: grant the index ≠ `last_grant`.
  - On handshake: capture A, B, C_in, set id = g, `last_grant` ← g, chunk index k ← 0, carry ← C_in, go to RUN.
- RUN, each cycle:
  - Drive `cla_5bit` with A[5k+4:5k], B[5k+4:5k] and the carry register.
  - Write its Sum into Sum[5k+4:5k] and its C_out into the carry register.
  - If k = NCHUNK-1, go to DONE; otherwise k ← k+1.
- DONE:
  - `out_valid` = 1.
  - `Sum`, `C_out`, `out_id` (and `ovf`) are stable and held.
  - On `out_valid & out_ready`, go to IDLE.
- `req_ready` = 0 in RUN and DONE; requests wait, with no queueing.
- A requester may drop `req_valid` before it is granted; no obligation is created.
- Arithmetic: Sum = (A + B + C_in) mod 2^W; C_out = (A + B + C_in) ≥ 2^W.
- Reset:
  - State = IDLE, `last_grant` = 1 (requester 0 wins the first contention).
  - `out_valid` = 0, `req_ready` = 0 while `rst` is high.
  - `Sum` = 0, `C_out` = 0, `out_id` = 0, `ovf` = 0, k = 0, carry = 0.
  - Reset during RUN or DONE discards the job; no partial result is ever presented.

## Timing
- Request accepted at edge T. RUN occupies cycles T+1..T+NCHUNK. `out_valid` rises after edge T+NCHUNK, i.e. NCHUNK+1 cycles after acceptance (5 by default).
- The earliest next acceptance is the edge after the output handshake. Throughput is one job per NCHUNK+2 cycles with `out_ready` held high.
- `req_ready` depends combinationally on `req_valid`, state and `last_grant`. No output depends combinationally on `out_ready`.
- The `cla_5bit` path is combinational within one cycle; the carry register breaks the chain between chunks.

## Configuration
- `CLA_SCHED_OVF_EN` defined:
  - Port `ovf` exists.
  - ovf = (A[W-1] == B[W-1]) && (Sum[W-1] != A[W-1]), computed on the final chunk and registered with `Sum`.
  - Valid whenever `out_valid` = 1.
- `CLA_SCHED_OVF_EN` undefined: no `ovf` port and no related logic; all other behaviour is identical.

## Test plan
- Carry ripple across all chunks: req0, A0=0x00001, B0=0xFFFFF, C_in0=0.
  - Expect `out_valid` 5 cycles after acceptance.
  - Sum=0x00000, C_out=1, out_id=0.
- Chunk boundary and carry-in:
  - A=0x0001F, B=0x00001, C_in=0 → Sum=0x00020, C_out=0.
  - A=0x7FFFF, B=0, C_in=1 → Sum=0x80000, C_out=0, ovf=1 (with macro).
- Contention: both `req_valid` high from reset, `out_ready`=1.
  - Grants run req0, req1, req0, req1; `out_id` alternates 0,1,0,1.
  - `req_ready` is never high on both bits.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE.
  - `Sum`, `C_out` and `out_id` stay constant; `req_ready`=00 throughout.
  - The single handshake occurs when `out_ready` rises.
- Reset mid-job: assert `rst` for one cycle during RUN at k=2.
  - `out_valid` never pulses for that job; all outputs read 0.
  - The next req1 request is granted first cycle after reset if it is the only one valid.
  - If both are valid, req0 wins.
